// File: rtl/dds_sine_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_sine_gen_if
// Description : Register-write bus from the control block into the DDS sine
//               generator.
//               cfg_wr_i   - one-cycle write strobe
//               cfg_ch_i   - target channel index
//               cfg_sel_i  - register select (0 FTW, 1 POFF, 2 AMP, 3 reserved)
//               cfg_data_i - write data, PHASE_W bits
//               master : control block (drives the bus)
//               slave  : dds_sine_gen (receives the bus)
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_sine_gen_if #(
  parameter int PHASE_W = 32
);
  logic               cfg_wr_i;
  logic [2:0]         cfg_ch_i;
  logic [1:0]         cfg_sel_i;
  logic [PHASE_W-1:0] cfg_data_i;

  modport master (
    output cfg_wr_i,
    output cfg_ch_i,
    output cfg_sel_i,
    output cfg_data_i
  );

  modport slave (
    input cfg_wr_i,
    input cfg_ch_i,
    input cfg_sel_i,
    input cfg_data_i
  );
endinterface
`default_nettype wire

// File: rtl/dds_sine_gen.sv
`default_nettype none
// ============================================================================
// Module      : dds_sine_gen
// Description : Multi-channel DDS sine generator. Each channel runs a phase
//               accumulator with programmable tuning word (FTW) and phase
//               offset (POFF); all channels read one shared quarter-wave
//               table and fold it into a full offset-binary sine.
//               Ports:
//                 sys_clk_i  - system clock, rising edge
//                 sys_rst_i  - synchronous active-high reset
//                 ch_en_i    - per-channel run enable
//                 sync_i     - one-cycle pulse, clears all accumulators
//                 cfg        - register-write bus (dds_sine_gen_if.slave)
//                 dout_o     - samples, channel k at [k*DAC_W +: DAC_W]
//                 dout_vld_o - per-channel sample valid
//               Optional feature macro: DDS_AMP_SCALE_EN adds a per-channel
//               amplitude register and one extra pipeline stage
//               (latency 4 instead of 3).
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sine_gen #(
  parameter int CH_NUM  = 2,
  parameter int DAC_W   = 12,
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 8,
  parameter int AMP_W   = 10
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic [CH_NUM-1:0]       ch_en_i,
  input  logic                    sync_i,
  dds_sine_gen_if.slave           cfg,
  output logic [CH_NUM*DAC_W-1:0] dout_o,
  output logic [CH_NUM-1:0]       dout_vld_o
);

  localparam int  c_MAG_W = DAC_W - 1;
  localparam int  c_QN    = 1 << (ADDR_W - 2);
  localparam int  c_QA_W  = ADDR_W - 1;
  localparam int  c_MID   = (1 << (DAC_W - 1)) - 1;
  localparam real c_PI    = 3.14159265358979323846;

  localparam logic [DAC_W-1:0]  c_MID_D = DAC_W'(c_MID);
  localparam logic [c_QA_W-1:0] c_QN_A  = c_QA_W'(c_QN);

  // Elaboration-time sine: Taylor series, accurate to double precision
  // over 0..pi/2, which is the only range the quarter table needs.
  function automatic real f_sin(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Q[i] = round-half-up(MID * sin(pi/2 * i / QN)); all values are >= 0,
  // so truncating (x + 0.5) is round-half-up.
  function automatic int f_qval(input int i);
    real ph;
    ph = c_PI / 2.0 * real'(i) / real'(c_QN);
    return $rtoi(real'(c_MID) * f_sin(ph) + 0.5);
  endfunction

  if (CH_NUM < 1 || CH_NUM > 8 || ADDR_W < 3 || AMP_W < 1 || AMP_W >= PHASE_W) begin : g_param_err
    $error("dds_sine_gen: illegal parameter combination");
  end

  // Shared quarter-wave ROM, QN+1 entries so that both 0 and the peak
  // are stored exactly and no special case is needed at the fold points.
  logic [c_MAG_W-1:0] w_qtab [c_QN+1];

  for (genvar i = 0; i <= c_QN; i++) begin : g_qtab
    localparam int c_QV = f_qval(i);
    assign w_qtab[i] = c_MAG_W'(c_QV);
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic                 w_wr;
    logic [PHASE_W-1:0]   r_ftw;
    logic [PHASE_W-1:0]   r_poff;
    logic [PHASE_W-1:0]   r_acc;
    logic [PHASE_W-1:0]   w_phase;
    logic [1:0]           r_quad;
    logic [ADDR_W-3:0]    r_idx;
    logic                 r_v1;
    logic [c_QA_W-1:0]    w_qaddr;
    logic [c_MAG_W-1:0]   r_mag;
    logic                 r_neg;
    logic                 r_v2;
    logic [c_MAG_W-1:0]   w_fin_mag;
    logic                 w_fin_neg;
    logic                 w_fin_v;
    logic [DAC_W-1:0]     r_dout;
    logic                 r_vld;

    // Channel indices at or above CH_NUM never match any k, so writes to
    // them fall through with no effect.
    assign w_wr = cfg.cfg_wr_i && (cfg.cfg_ch_i == 3'(k));

    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        r_ftw  <= '0;
        r_poff <= '0;
      end else if (w_wr) begin
        case (cfg.cfg_sel_i)
          2'd0:    r_ftw  <= cfg.cfg_data_i;
          2'd1:    r_poff <= cfg.cfg_data_i;
          default: ;
        endcase
      end
    end

    // Stage 0: accumulator. A disabled channel parks at 0 so the first
    // enabled cycle always starts from phase 0.
    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        r_acc <= '0;
      end else if (sync_i) begin
        r_acc <= '0;
      end else if (ch_en_i[k]) begin
        r_acc <= r_acc + r_ftw;
      end else begin
        r_acc <= '0;
      end
    end

    // Stage 1: apply phase offset and split the LUT address.
    assign w_phase = r_acc + r_poff;

    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        r_quad <= '0;
        r_idx  <= '0;
        r_v1   <= 1'b0;
      end else begin
        r_quad <= w_phase[PHASE_W-1 -: 2];
        r_idx  <= w_phase[PHASE_W-3 -: ADDR_W-2];
        r_v1   <= ch_en_i[k];
      end
    end

    // Stage 2: fold. Odd quadrants read the table mirrored, upper half
    // of the cycle is negative.
    assign w_qaddr = r_quad[0] ? (c_QN_A - {1'b0, r_idx}) : {1'b0, r_idx};

    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        r_mag <= '0;
        r_neg <= 1'b0;
        r_v2  <= 1'b0;
      end else begin
        r_mag <= w_qtab[w_qaddr];
        r_neg <= r_quad[1];
        r_v2  <= r_v1;
      end
    end

`ifdef DDS_AMP_SCALE_EN
    localparam logic [AMP_W:0] c_UNITY = {1'b1, {AMP_W{1'b0}}};

    logic [AMP_W:0]         r_amp;
    logic [c_MAG_W+AMP_W:0] w_prod;
    logic [c_MAG_W-1:0]     r_mag_s;
    logic                   r_neg_s;
    logic                   r_v3;

    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        r_amp <= c_UNITY;
      end else if (w_wr && cfg.cfg_sel_i == 2'd2) begin
        r_amp <= (cfg.cfg_data_i[AMP_W:0] > c_UNITY) ? c_UNITY : cfg.cfg_data_i[AMP_W:0];
      end
    end

    // Amp never exceeds unity, so the scaled magnitude fits in c_MAG_W.
    assign w_prod = (c_MAG_W+AMP_W+1)'(r_mag) * (c_MAG_W+AMP_W+1)'(r_amp);

    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        r_mag_s <= '0;
        r_neg_s <= 1'b0;
        r_v3    <= 1'b0;
      end else begin
        r_mag_s <= c_MAG_W'(w_prod >> AMP_W);
        r_neg_s <= r_neg;
        r_v3    <= r_v2;
      end
    end

    assign w_fin_mag = r_mag_s;
    assign w_fin_neg = r_neg_s;
    assign w_fin_v   = r_v3;
`else
    assign w_fin_mag = r_mag;
    assign w_fin_neg = r_neg;
    assign w_fin_v   = r_v2;
`endif

    // Output stage: offset binary around MID; range 0..2*MID.
    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        r_dout <= c_MID_D;
        r_vld  <= 1'b0;
      end else begin
        r_vld <= w_fin_v;
        if (!w_fin_v) begin
          r_dout <= c_MID_D;
        end else if (w_fin_neg) begin
          r_dout <= c_MID_D - {1'b0, w_fin_mag};
        end else begin
          r_dout <= c_MID_D + {1'b0, w_fin_mag};
        end
      end
    end

    assign dout_o[k*DAC_W +: DAC_W] = r_dout;
    assign dout_vld_o[k]            = r_vld;
  end

endmodule
`default_nettype wire
